multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control sequencer for the RV32 subset datapath (PC, Add_PC, Instruction_Memory, Registers, MUX_ALUSrc, ALU, Sign_Extend). It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath's write enables and mux selects. It handshakes with a shared instruction/data memory port and counts retired instructions. It sits beside the datapath in CPU and replaces the single-cycle Control block.

## Interface
- No parameters.
- clk_i  in  1  clock; all state changes on its rising edge
- rst_i  in  1  reset; asynchronous, active-high
- start_i  in  1  run enable; sampled in IDLE and at each instruction boundary
- opcode_i  in  7  instr[6:0] from the datapath IR; valid from DECODE onward
- zero_i  in  1  ALU Zero flag, combinational in EXEC
- mem_ready_i  in  1  memory completes the access in the cycle where mem_req_o && mem_ready_i
- mem_req_o  out  1  memory request, held until ready
- mem_we_o  out  1  write request, valid with mem_req_o
- mem_addr_sel_o  out  1  0 = PC (fetch), 1 = ALU result (data)
- ir_write_o  out  1  latch IR and old PC
- pc_write_o  out  1  load PC
- pc_src_o  out  1  0 = PC+4, 1 = branch target
- reg_write_o  out  1  register file write
- mem_to_reg_o  out  1  WB source: 0 = ALU, 1 = memory data
- alu_src_o  out  1  MUX_ALUSrc select: 0 = RS2data, 1 = immediate
- alu_op_o  out  2  00 add, 01 sub, 10 R-funct, 11 I-funct
- busy_o  out  1  high in every state except IDLE
- illegal_o  out  1  one-cycle pulse on an unsupported opcode
- instr_cnt_o  out  32  retired-instruction count

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB.
- IDLE: go to FETCH when start_i = 1.
- FETCH: mem_req_o=1, mem_addr_sel_o=0. On the ready cycle, assert ir_write_o and pc_write_o (pc_src_o=0), then go to DECODE. Otherwise hold.
- DECODE: classify opcode_i and latch the class: R 0110011, I 0010011, LW 0000011, SW 0100011, BEQ 1100011.
  - Any other opcode: pulse illegal_o, do not retire, and go to the boundary.
  - Supported opcodes go to EXEC.
- EXEC:
  - alu_op_o per class: R=10, I=11, LW/SW=00, BEQ=01.
  - alu_src_o=1 for I, LW and SW.
  - BEQ: pc_write_o = zero_i, pc_src_o=1, then retire.
  - LW/SW go to MEM. R/I go to WB.
- MEM: mem_req_o=1, mem_addr_sel_o=1, mem_we_o=1 for SW. Hold until ready. On ready, LW goes to WB and SW retires.
- WB: reg_write_o=1 for one cycle; mem_to_reg_o=1 for LW. Then retire.
- Retire: instr_cnt_o increments by 1, wrapping 0xFFFFFFFF to 0. Then at the boundary, go to FETCH if start_i=1, else IDLE.
- Outputs are decoded from the registered state and class (Moore). Exceptions: pc_write_o and ir_write_o in FETCH, and pc_write_o in EXEC, are Mealy on mem_ready_i / zero_i.

## Timing
- Reset state: IDLE, class cleared, instr_cnt_o=0. Every output is 0 while rst_i is high and in IDLE.
- Minimum latency with zero-wait memory: BEQ 3 cycles, R/I/SW 4, LW 5. Each memory wait cycle adds 1.
- start_i deasserted mid-instruction has no effect until the boundary.
- rst_i asserted mid-access aborts the instruction immediately: mem_req_o drops asynchronously and the count is not incremented.
- mem_ready_i outside FETCH/MEM is ignored.
- illegal_o and instr_cnt_o increment are mutually exclusive per instruction.

## Structure
- Shared package cpu_ctrl_pkg holds:
  - state enum;
  - opcode constants;
  - ALUOp encoding;
  - instruction-class enum.
- One sub-module, ctrl_decode: opcode_i to class plus legal flag, purely combinational. Instantiated in the top.
- Top holds the FSM, class register and counter.

## Test plan
- Reset, then start_i=1, opcode R, zero-wait memory: states FETCH→DECODE→EXEC→WB; reg_write_o pulses in cycle 4; instr_cnt_o=1; alu_op_o=10 in EXEC.
- LW with mem_ready_i low for 2 cycles in FETCH and 1 in MEM: total 8 cycles; mem_to_reg_o=1 and reg_write_o=1 in WB; mem_we_o=0 throughout.
- SW, zero-wait: mem_we_o=1 only in MEM; reg_write_o never asserted; retires after 4 cycles.
- BEQ: with zero_i=1, pc_write_o=1 and pc_src_o=1 in EXEC; with zero_i=0, no PC write in EXEC; both retire after 3 cycles.
- Opcode 1111111: illegal_o pulses once in DECODE; instr_cnt_o unchanged; next cycle is FETCH.
- rst_i asserted in MEM while waiting: all outputs 0 immediately; state IDLE; instr_cnt_o=0. start_i=0 at a boundary returns to IDLE with busy_o=0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle control sequencer: FSM states,
// supported opcodes, ALUOp encodings and the latched instruction class.
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5
   } state_e;

   typedef enum logic [2:0] {
      CLS_NONE = 3'd0,
      CLS_R    = 3'd1,
      CLS_I    = 3'd2,
      CLS_LW   = 3'd3,
      CLS_SW   = 3'd4,
      CLS_BEQ  = 3'd5
   } class_e;

   localparam logic [6:0] OPC_R   = 7'b0110011;
   localparam logic [6:0] OPC_I   = 7'b0010011;
   localparam logic [6:0] OPC_LW  = 7'b0000011;
   localparam logic [6:0] OPC_SW  = 7'b0100011;
   localparam logic [6:0] OPC_BEQ = 7'b1100011;

   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_SUB    = 2'b01;
   localparam logic [1:0] ALUOP_RFUNCT = 2'b10;
   localparam logic [1:0] ALUOP_IFUNCT = 2'b11;

   // ALU operation required by an instruction class
   function automatic logic [1:0] class_alu_op(input class_e cls);
      case (cls)
         CLS_R:   return ALUOP_RFUNCT;
         CLS_I:   return ALUOP_IFUNCT;
         CLS_BEQ: return ALUOP_SUB;
         default: return ALUOP_ADD;
      endcase
   endfunction

   // Classes whose second ALU operand is the sign-extended immediate
   function automatic logic class_uses_imm(input class_e cls);
      return (cls == CLS_I) || (cls == CLS_LW) || (cls == CLS_SW);
   endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Opcode classifier: maps instr[6:0] to an instruction class and a legal flag.
module ctrl_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [6:0] opcode_i,
   output class_e     class_o,
   output logic       legal_o
);

   // Pure lookup; unsupported opcodes yield CLS_NONE and legal_o = 0
   always_comb begin
      class_o = CLS_NONE;
      legal_o = 1'b1;
      case (opcode_i)
         OPC_R:   class_o = CLS_R;
         OPC_I:   class_o = CLS_I;
         OPC_LW:  class_o = CLS_LW;
         OPC_SW:  class_o = CLS_SW;
         OPC_BEQ: class_o = CLS_BEQ;
         default: legal_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives datapath enables and mux selects,
// handshakes with the shared memory port and counts retired instructions.
module multicycle_ctrl
   import cpu_ctrl_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [6:0]  opcode_i,
   input  logic        zero_i,
   input  logic        mem_ready_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic        mem_addr_sel_o,
   output logic        ir_write_o,
   output logic        pc_write_o,
   output logic        pc_src_o,
   output logic        reg_write_o,
   output logic        mem_to_reg_o,
   output logic        alu_src_o,
   output logic [1:0]  alu_op_o,
   output logic        busy_o,
   output logic        illegal_o,
   output logic [31:0] instr_cnt_o
);

   state_e      state_q, state_d;
   class_e      class_q, class_d;
   logic [31:0] cnt_q, cnt_d;
   logic        retire;

   class_e      dec_class;
   logic        dec_legal;

   ctrl_decode u_decode (
      .opcode_i (opcode_i),
      .class_o  (dec_class),
      .legal_o  (dec_legal)
   );

   // State, class and counter registers; reset aborts any access in flight
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         class_q <= CLS_NONE;
         cnt_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         class_q <= class_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic; every instruction ends at a boundary that re-samples start_i
   always_comb begin
      state_d = state_q;
      class_d = class_q;
      retire  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (mem_ready_i) state_d = ST_DECODE;
         end
         ST_DECODE: begin
            if (dec_legal) begin
               class_d = dec_class;
               state_d = ST_EXEC;
            end else begin
               // Unsupported opcode: abandon without retiring
               class_d = CLS_NONE;
               state_d = start_i ? ST_FETCH : ST_IDLE;
            end
         end
         ST_EXEC: begin
            case (class_q)
               CLS_BEQ: begin
                  retire  = 1'b1;
                  state_d = start_i ? ST_FETCH : ST_IDLE;
               end
               CLS_LW, CLS_SW: state_d = ST_MEM;
               CLS_R, CLS_I:   state_d = ST_WB;
               default:        state_d = ST_IDLE;
            endcase
         end
         ST_MEM: begin
            if (mem_ready_i) begin
               if (class_q == CLS_LW) begin
                  state_d = ST_WB;
               end else begin
                  retire  = 1'b1;
                  state_d = start_i ? ST_FETCH : ST_IDLE;
               end
            end
         end
         ST_WB: begin
            retire  = 1'b1;
            state_d = start_i ? ST_FETCH : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // Natural 32-bit wrap from 0xFFFFFFFF to 0
      cnt_d = retire ? cnt_q + 32'd1 : cnt_q;
   end

   // Output decode from registered state/class; FETCH write enables follow
   // mem_ready_i and the EXEC PC write follows zero_i combinationally
   always_comb begin
      mem_req_o      = 1'b0;
      mem_we_o       = 1'b0;
      mem_addr_sel_o = 1'b0;
      ir_write_o     = 1'b0;
      pc_write_o     = 1'b0;
      pc_src_o       = 1'b0;
      reg_write_o    = 1'b0;
      mem_to_reg_o   = 1'b0;
      alu_src_o      = 1'b0;
      alu_op_o       = ALUOP_ADD;
      busy_o         = (state_q != ST_IDLE);
      illegal_o      = (state_q == ST_DECODE) && !dec_legal;
      case (state_q)
         ST_FETCH: begin
            mem_req_o  = 1'b1;
            ir_write_o = mem_ready_i;
            pc_write_o = mem_ready_i;
         end
         ST_EXEC: begin
            alu_op_o  = class_alu_op(class_q);
            alu_src_o = class_uses_imm(class_q);
            if (class_q == CLS_BEQ) begin
               pc_write_o = zero_i;
               pc_src_o   = 1'b1;
            end
         end
         ST_MEM: begin
            // The datapath has no ALU output register, so the ALU controls
            // stay applied while the ALU result addresses memory
            alu_op_o       = class_alu_op(class_q);
            alu_src_o      = class_uses_imm(class_q);
            mem_req_o      = 1'b1;
            mem_addr_sel_o = 1'b1;
            mem_we_o       = (class_q == CLS_SW);
         end
         ST_WB: begin
            // Same reason: R/I write-back data is the live ALU result
            alu_op_o     = class_alu_op(class_q);
            alu_src_o    = class_uses_imm(class_q);
            reg_write_o  = 1'b1;
            mem_to_reg_o = (class_q == CLS_LW);
         end
         default: ;
      endcase
   end

   assign instr_cnt_o = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle output signatures for each
// instruction class, wait states, illegal opcode, back-to-back and reset abort.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic [6:0]  opcode_i;
   logic        zero_i;
   logic        mem_ready_i;
   logic        mem_req_o, mem_we_o, mem_addr_sel_o, ir_write_o, pc_write_o;
   logic        pc_src_o, reg_write_o, mem_to_reg_o, alu_src_o, busy_o, illegal_o;
   logic [1:0]  alu_op_o;
   logic [31:0] instr_cnt_o;

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_cnt = 32'd0;

   // Output signature bit positions
   localparam logic [12:0] REQ  = 13'h1000;
   localparam logic [12:0] WE   = 13'h0800;
   localparam logic [12:0] ASEL = 13'h0400;
   localparam logic [12:0] IRW  = 13'h0200;
   localparam logic [12:0] PCW  = 13'h0100;
   localparam logic [12:0] PCS  = 13'h0080;
   localparam logic [12:0] RW   = 13'h0040;
   localparam logic [12:0] M2R  = 13'h0020;
   localparam logic [12:0] ASRC = 13'h0010;
   localparam logic [12:0] OP_ADD = 13'h0000;
   localparam logic [12:0] OP_SUB = 13'h0004;
   localparam logic [12:0] OP_R   = 13'h0008;
   localparam logic [12:0] OP_I   = 13'h000C;
   localparam logic [12:0] BUSY = 13'h0002;
   localparam logic [12:0] ILL  = 13'h0001;

   localparam logic [12:0] S_FRDY  = REQ | IRW | PCW | BUSY;
   localparam logic [12:0] S_FWAIT = REQ | BUSY;
   localparam logic [12:0] S_DEC   = BUSY;

   logic [12:0] obs;
   assign obs = {mem_req_o, mem_we_o, mem_addr_sel_o, ir_write_o, pc_write_o, pc_src_o,
                 reg_write_o, mem_to_reg_o, alu_src_o, alu_op_o, busy_o, illegal_o};

   logic [12:0] obs_tab [0:9];

   multicycle_ctrl dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .start_i        (start_i),
      .opcode_i       (opcode_i),
      .zero_i         (zero_i),
      .mem_ready_i    (mem_ready_i),
      .mem_req_o      (mem_req_o),
      .mem_we_o       (mem_we_o),
      .mem_addr_sel_o (mem_addr_sel_o),
      .ir_write_o     (ir_write_o),
      .pc_write_o     (pc_write_o),
      .pc_src_o       (pc_src_o),
      .reg_write_o    (reg_write_o),
      .mem_to_reg_o   (mem_to_reg_o),
      .alu_src_o      (alu_src_o),
      .alu_op_o       (alu_op_o),
      .busy_o         (busy_o),
      .illegal_o      (illegal_o),
      .instr_cnt_o    (instr_cnt_o)
   );

   always #5 clk = ~clk;

   // Stimulus only: launch from IDLE and record the output signature of n cycles
   task automatic run_instr(input logic [6:0] op, input int n, input logic [9:0] start_bits,
                            input logic [9:0] rdy_bits, input logic z);
      opcode_i = op; zero_i = z; start_i = 1'b1; mem_ready_i = 1'b0;
      @(posedge clk); #1;
      for (int c = 0; c < n; c++) begin
         start_i = start_bits[c];
         mem_ready_i = rdy_bits[c];
         #1;
         obs_tab[c] = obs;
         @(posedge clk); #1;
      end
      start_i = 1'b0; mem_ready_i = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1; start_i = 1'b1; opcode_i = 7'b0110011; zero_i = 1'b1; mem_ready_i = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      checks++; if (obs !== 13'h0) begin failures++; $display("FAIL reset_outputs: got %h expected %h", obs, 13'h0); end
      checks++; if (instr_cnt_o !== 32'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", instr_cnt_o); end
      start_i = 1'b0;
      rst_i = 1'b0;
      @(posedge clk); #2;
      checks++; if (obs !== 13'h0) begin failures++; $display("FAIL idle_outputs: got %h expected %h", obs, 13'h0); end
   endtask

   task automatic test_r_type();
      logic [12:0] e [0:3];
      e[0] = S_FRDY; e[1] = S_DEC; e[2] = OP_R | BUSY; e[3] = RW | OP_R | BUSY;
      run_instr(7'b0110011, 4, 10'b0, 10'h3FF, 1'b0);
      exp_cnt = exp_cnt + 32'd1;
      for (int c = 0; c < 4; c++) begin
         checks++; if (obs_tab[c] !== e[c]) begin failures++; $display("FAIL r_type cycle %0d: got %h expected %h", c + 1, obs_tab[c], e[c]); end
      end
      checks++; if (obs !== 13'h0) begin failures++; $display("FAIL r_type_idle: got %h expected %h", obs, 13'h0); end
      checks++; if (instr_cnt_o !== exp_cnt) begin failures++; $display("FAIL r_type_count: got %0d expected %0d", instr_cnt_o, exp_cnt); end
   endtask

   task automatic test_i_type();
      logic [12:0] e [0:3];
      e[0] = S_FRDY; e[1] = S_DEC; e[2] = ASRC | OP_I | BUSY; e[3] = RW | ASRC | OP_I | BUSY;
      run_instr(7'b0010011, 4, 10'b0, 10'h3FF, 1'b0);
      exp_cnt = exp_cnt + 32'd1;
      for (int c = 0; c < 4; c++) begin
         checks++; if (obs_tab[c] !== e[c]) begin failures++; $display("FAIL i_type cycle %0d: got %h expected %h", c + 1, obs_tab[c], e[c]); end
      end
      checks++; if (instr_cnt_o !== exp_cnt) begin failures++; $display("FAIL i_type_count: got %0d expected %0d", instr_cnt_o, exp_cnt); end
   endtask

   task automatic test_lw_wait();
      logic [12:0] e [0:7];
      e[0] = S_FWAIT; e[1] = S_FWAIT; e[2] = S_FRDY; e[3] = S_DEC;
      e[4] = ASRC | OP_ADD | BUSY;
      e[5] = REQ | ASEL | ASRC | BUSY; e[6] = REQ | ASEL | ASRC | BUSY;
      e[7] = RW | M2R | ASRC | BUSY;
      // ready: 0,0,1 in FETCH; 1,1 ignored in DECODE/EXEC; 0,1 in MEM; 1 ignored in WB
      run_instr(7'b0000011, 8, 10'b0, 10'b0011011100, 1'b0);
      exp_cnt = exp_cnt + 32'd1;
      for (int c = 0; c < 8; c++) begin
         checks++; if (obs_tab[c] !== e[c]) begin failures++; $display("FAIL lw_wait cycle %0d: got %h expected %h", c + 1, obs_tab[c], e[c]); end
      end
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL lw_done_busy: got %b expected 0", busy_o); end
      checks++; if (instr_cnt_o !== exp_cnt) begin failures++; $display("FAIL lw_count: got %0d expected %0d", instr_cnt_o, exp_cnt); end
   endtask

   task automatic test_sw();
      logic [12:0] e [0:3];
      e[0] = S_FRDY; e[1] = S_DEC; e[2] = ASRC | BUSY; e[3] = REQ | WE | ASEL | ASRC | BUSY;
      run_instr(7'b0100011, 4, 10'b0, 10'h3FF, 1'b0);
      exp_cnt = exp_cnt + 32'd1;
      for (int c = 0; c < 4; c++) begin
         checks++; if (obs_tab[c] !== e[c]) begin failures++; $display("FAIL sw cycle %0d: got %h expected %h", c + 1, obs_tab[c], e[c]); end
      end
      checks++; if (obs !== 13'h0) begin failures++; $display("FAIL sw_idle: got %h expected %h", obs, 13'h0); end
      checks++; if (instr_cnt_o !== exp_cnt) begin failures++; $display("FAIL sw_count: got %0d expected %0d", instr_cnt_o, exp_cnt); end
   endtask

   task automatic test_beq();
      logic [12:0] e [0:1];
      e[0] = PCW | PCS | OP_SUB | BUSY;
      e[1] = PCS | OP_SUB | BUSY;
      for (int k = 0; k < 2; k++) begin
         run_instr(7'b1100011, 3, 10'b0, 10'h3FF, (k == 0));
         exp_cnt = exp_cnt + 32'd1;
         checks++; if (obs_tab[1] !== S_DEC) begin failures++; $display("FAIL beq_decode z=%0d: got %h expected %h", (k == 0), obs_tab[1], S_DEC); end
         checks++; if (obs_tab[2] !== e[k]) begin failures++; $display("FAIL beq_exec z=%0d: got %h expected %h", (k == 0), obs_tab[2], e[k]); end
         checks++; if (obs !== 13'h0) begin failures++; $display("FAIL beq_idle z=%0d: got %h expected %h", (k == 0), obs, 13'h0); end
         checks++; if (instr_cnt_o !== exp_cnt) begin failures++; $display("FAIL beq_count z=%0d: got %0d expected %0d", (k == 0), instr_cnt_o, exp_cnt); end
      end
   endtask

   task automatic test_illegal();
      logic [12:0] e [0:3];
      e[0] = S_FRDY; e[1] = BUSY | ILL; e[2] = S_FRDY; e[3] = BUSY | ILL;
      // start held through the first DECODE so the next cycle is FETCH
      run_instr(7'b1111111, 4, 10'b0000000111, 10'h3FF, 1'b0);
      for (int c = 0; c < 4; c++) begin
         checks++; if (obs_tab[c] !== e[c]) begin failures++; $display("FAIL illegal cycle %0d: got %h expected %h", c + 1, obs_tab[c], e[c]); end
      end
      checks++; if (obs !== 13'h0) begin failures++; $display("FAIL illegal_idle: got %h expected %h", obs, 13'h0); end
      checks++; if (instr_cnt_o !== exp_cnt) begin failures++; $display("FAIL illegal_count: got %0d expected %0d", instr_cnt_o, exp_cnt); end
   endtask

   task automatic test_back_to_back();
      logic [12:0] e [0:3];
      e[0] = S_FRDY; e[1] = S_DEC; e[2] = OP_R | BUSY; e[3] = RW | OP_R | BUSY;
      // start sampled high only at the first boundary
      run_instr(7'b0110011, 8, 10'b0000001000, 10'h3FF, 1'b0);
      exp_cnt = exp_cnt + 32'd2;
      for (int c = 0; c < 8; c++) begin
         checks++; if (obs_tab[c] !== e[c % 4]) begin failures++; $display("FAIL back_to_back cycle %0d: got %h expected %h", c + 1, obs_tab[c], e[c % 4]); end
      end
      checks++; if (obs !== 13'h0) begin failures++; $display("FAIL back_to_back_idle: got %h expected %h", obs, 13'h0); end
      checks++; if (instr_cnt_o !== exp_cnt) begin failures++; $display("FAIL back_to_back_count: got %0d expected %0d", instr_cnt_o, exp_cnt); end
   endtask

   task automatic test_reset_mid();
      opcode_i = 7'b0100011; zero_i = 1'b0; start_i = 1'b1; mem_ready_i = 1'b0;
      @(posedge clk); #1;              // FETCH
      start_i = 1'b0; mem_ready_i = 1'b1;
      @(posedge clk); #1;              // DECODE
      mem_ready_i = 1'b0;
      @(posedge clk); #1;              // EXEC
      @(posedge clk); #1;              // MEM, waiting
      #1;
      checks++; if (obs !== (REQ | WE | ASEL | ASRC | BUSY)) begin failures++; $display("FAIL mid_mem_wait: got %h expected %h", obs, REQ | WE | ASEL | ASRC | BUSY); end
      rst_i = 1'b1;
      #1;
      checks++; if (obs !== 13'h0) begin failures++; $display("FAIL mid_reset_outputs: got %h expected %h", obs, 13'h0); end
      checks++; if (instr_cnt_o !== 32'd0) begin failures++; $display("FAIL mid_reset_count: got %0d expected 0", instr_cnt_o); end
      mem_ready_i = 1'b1;
      @(posedge clk); #1;
      rst_i = 1'b0;
      @(posedge clk); #2;
      checks++; if (obs !== 13'h0) begin failures++; $display("FAIL post_reset_idle: got %h expected %h", obs, 13'h0); end
      checks++; if (instr_cnt_o !== 32'd0) begin failures++; $display("FAIL post_reset_count: got %0d expected 0", instr_cnt_o); end
      exp_cnt = 32'd0;
   endtask

   initial begin
      rst_i = 1'b1; start_i = 1'b0; opcode_i = 7'd0; zero_i = 1'b0; mem_ready_i = 1'b0;
      test_reset();
      test_r_type();
      test_i_type();
      test_lw_wait();
      test_sw();
      test_beq();
      test_illegal();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
